// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI master.
// One transaction in flight at a time, with a watchdog and an enforced idle gap between transactions.
module spi_arbiter #(
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] cmd0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rdy0,
    output logic        rdy1,
    output logic [15:0] rsp_data,
    output logic        err,
    output logic        busy,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_e;

    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    state_e      state_q;
    logic        ptr_q, owner_q, err_q;
    logic        gnt0_q, gnt1_q, rdy0_q, rdy1_q;
    logic [15:0] wd_q, gap_q, cmd_q, rsp_q;
    logic        pick1_d;

    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    assign pick1_d = req1 & (~req0 | ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            wd_q    <= '0;
            gap_q   <= '0;
            cmd_q   <= '0;
            rsp_q   <= '0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            rdy0_q <= 1'b0;
            rdy1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        owner_q <= pick1_d;
                        cmd_q   <= pick1_d ? cmd1 : cmd0;
                        gnt0_q  <= ~pick1_d;
                        gnt1_q  <= pick1_d;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // done is checked first so it beats a coincident timeout.
                    if (done) begin
                        rsp_q   <= rd_data;
                        err_q   <= 1'b0;
                        rdy0_q  <= ~owner_q;
                        rdy1_q  <= owner_q;
                        state_q <= RESP;
                    end else if (wd_q == WD_LAST) begin
                        rsp_q   <= 16'hFFFF;
                        err_q   <= 1'b1;
                        rdy0_q  <= ~owner_q;
                        rdy1_q  <= owner_q;
                        state_q <= RESP;
                    end else begin
                        wd_q <= wd_q + 16'd1;
                    end
                end
                RESP: begin
                    ptr_q <= ~owner_q;
                    gap_q <= '0;
                    if (GAP_CYC > 0) state_q <= GAP;
                    else             state_q <= IDLE;
                end
                GAP: begin
                    if (gap_q == GAP_LAST) state_q <= IDLE;
                    else                   gap_q   <= gap_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign wrt      = gnt0_q | gnt1_q;
    assign rdy0     = rdy0_q;
    assign rdy1     = rdy1_q;
    assign rsp_data = rsp_q;
    assign err      = err_q;
    assign cmd      = cmd_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of grant order, response contents and cycle timing.
module tb_spi_arbiter;
    localparam int GAP = 4;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, done;
    logic [15:0] cmd0, cmd1, rd_data;
    logic        gnt0, gnt1, rdy0, rdy1, err, busy, wrt;
    logic [15:0] rsp_data, cmd;
    logic        b_gnt0, b_gnt1, b_rdy0, b_rdy1, b_err, b_busy, b_wrt;
    logic [15:0] b_rsp_data, b_cmd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    spi_arbiter #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
        .gnt0(gnt0), .gnt1(gnt1), .rdy0(rdy0), .rdy1(rdy1), .rsp_data(rsp_data),
        .err(err), .busy(busy), .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data)
    );

    spi_arbiter #(.GAP_CYC(0), .TIMEOUT_CYC(TO)) dut_b (
        .clk(clk), .rst(rst), .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rdy0(b_rdy0), .rdy1(b_rdy1), .rsp_data(b_rsp_data),
        .err(b_err), .busy(b_busy), .wrt(b_wrt), .cmd(b_cmd), .done(done), .rd_data(rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; done = 1'b1;
        cmd0 = 16'h1234; cmd1 = 16'h4321; rd_data = 16'h5555;
        step();
        step();
        checks++; if ({gnt0, gnt1, rdy0, rdy1, wrt, busy, err} !== 7'b0) begin errors++;
            $display("FAIL reset_ctl got %b exp 0", {gnt0, gnt1, rdy0, rdy1, wrt, busy, err}); end
        checks++; if (rsp_data !== 16'h0) begin errors++;
            $display("FAIL reset_rsp got %h exp 0000", rsp_data); end
        checks++; if (cmd !== 16'h0) begin errors++;
            $display("FAIL reset_cmd got %h exp 0000", cmd); end
        checks++; if ({b_gnt0, b_gnt1, b_rdy0, b_rdy1, b_wrt, b_busy, b_err} !== 7'b0) begin errors++;
            $display("FAIL reset_ctl_b got %b exp 0", {b_gnt0, b_gnt1, b_rdy0, b_rdy1, b_wrt, b_busy, b_err}); end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; done = 1'b0;
        step();
    endtask

    task automatic test_single();
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        req0 = 1'b1; cmd0 = 16'hA55A;
        step();
        checks++; if ({gnt0, gnt1, wrt} !== 3'b101) begin errors++;
            $display("FAIL single_gnt got %b exp 101", {gnt0, gnt1, wrt}); end
        checks++; if (cmd !== 16'hA55A) begin errors++;
            $display("FAIL single_cmd got %h exp a55a", cmd); end
        req0 = 1'b0; cmd0 = 16'h0000;
        repeat (7) step();
        checks++; if ({busy, rdy0, rdy1} !== 3'b100) begin errors++;
            $display("FAIL single_wait got %b exp 100", {busy, rdy0, rdy1}); end
        step();
        done = 1'b1; rd_data = 16'h1234;
        step();
        done = 1'b0; rd_data = 16'hDEAD;
        checks++; if ({rdy0, rdy1, err} !== 3'b100) begin errors++;
            $display("FAIL single_rdy got %b exp 100", {rdy0, rdy1, err}); end
        checks++; if (rsp_data !== 16'h1234) begin errors++;
            $display("FAIL single_rsp got %h exp 1234", rsp_data); end
        checks++; if (cmd !== 16'hA55A) begin errors++;
            $display("FAIL single_cmd_hold got %h exp a55a", cmd); end
        repeat (GAP) step();
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL single_gap_busy got %b exp 1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL single_idle got %b exp 0", busy); end
    endtask

    task automatic test_contention();
        int  prev_d;
        logic got;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; done = 1'b0;
        cmd0 = 16'h1111; cmd1 = 16'h2222;
        step();
        step();
        rst = 1'b0;
        prev_d = 0;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                step();
                got = wrt;
            end
            checks++; if (!got || {gnt1, gnt0} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++;
                $display("FAIL cont_order%0d got %b exp owner %0d", i, {gnt1, gnt0}, i % 2); end
            if (i > 0) begin
                checks++; if (cyc != prev_d + GAP + 3) begin errors++;
                    $display("FAIL cont_spacing%0d got %0d exp %0d", i, cyc - prev_d, GAP + 3); end
            end
            step();
            step();
            done = 1'b1; rd_data = 16'(i);
            prev_d = cyc;
            step();
            done = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_timeout();
        int   w;
        logic early, got;
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        req1 = 1'b1; cmd1 = 16'hBEEF;
        step();
        checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++;
            $display("FAIL to_gnt got %b exp 10", {gnt1, gnt0}); end
        w = cyc; req1 = 1'b0;
        early = 1'b0;
        repeat (TO) begin
            step();
            if (rdy0 | rdy1) early = 1'b1;
        end
        step();
        checks++; if (early || {rdy1, rdy0, err} !== 3'b101) begin errors++;
            $display("FAIL to_rdy got %b early %b exp 101", {rdy1, rdy0, err}, early); end
        checks++; if (rsp_data !== 16'hFFFF) begin errors++;
            $display("FAIL to_rsp got %h exp ffff", rsp_data); end
        req0 = 1'b1; cmd0 = 16'h5555;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            got = wrt;
        end
        checks++; if (!got || gnt0 !== 1'b1 || cyc != w + TO + 1 + 2 + GAP) begin errors++;
            $display("FAIL to_next_gnt got cycle %0d exp %0d", cyc - w, TO + 3 + GAP); end
        req0 = 1'b0;
        step();
        step();
        done = 1'b1; rd_data = 16'h0042;
        step();
        done = 1'b0;
        checks++; if ({rdy0, err} !== 2'b10 || rsp_data !== 16'h0042) begin errors++;
            $display("FAIL to_next_rsp got %b %h exp 10 0042", {rdy0, err}, rsp_data); end
    endtask

    task automatic test_race();
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        req0 = 1'b1; cmd0 = 16'h0101;
        step();
        req0 = 1'b0;
        repeat (TO) step();
        done = 1'b1; rd_data = 16'h0F0F;
        step();
        done = 1'b0;
        checks++; if ({rdy0, err} !== 2'b10) begin errors++;
            $display("FAIL race_rdy got %b exp 10", {rdy0, err}); end
        checks++; if (rsp_data !== 16'h0F0F) begin errors++;
            $display("FAIL race_rsp got %h exp 0f0f", rsp_data); end
    endtask

    task automatic test_reset_wait();
        logic bad, got;
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        req0 = 1'b1; cmd0 = 16'h0C0C;
        step();
        checks++; if (gnt0 !== 1'b1) begin errors++;
            $display("FAIL rw_gnt0 got %b exp 1", gnt0); end
        req0 = 1'b0;
        step();
        step();
        done = 1'b1; rd_data = 16'h7E57;
        step();
        done = 1'b0;
        req1 = 1'b1; cmd1 = 16'hC1C1;
        got = 1'b0;
        for (int n = 0; n < 12 && !got; n++) begin
            step();
            got = gnt1;
        end
        checks++; if (!got) begin errors++;
            $display("FAIL rw_gnt1 got %b exp 1", got); end
        req1 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        done = 1'b1; rd_data = 16'h9999;
        bad = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            done = 1'b0;
            if ({gnt0, gnt1, rdy0, rdy1, wrt, busy, err} !== 7'b0 || rsp_data !== 16'h0 || cmd !== 16'h0)
                bad = 1'b1;
        end
        checks++; if (bad) begin errors++;
            $display("FAIL rw_silent got nonzero outputs exp all 0"); end
        req0 = 1'b1; req1 = 1'b1;
        step();
        checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++;
            $display("FAIL rw_ptr got %b exp 01", {gnt1, gnt0}); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_gap0();
        int   w;
        logic got;
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        req1 = 1'b1; cmd1 = 16'h3C3C;
        step();
        checks++; if ({b_gnt1, b_wrt} !== 2'b11) begin errors++;
            $display("FAIL gap0_gnt got %b exp 11", {b_gnt1, b_wrt}); end
        w = cyc;
        step();
        step();
        done = 1'b1; rd_data = 16'h6666;
        step();
        done = 1'b0;
        checks++; if ({b_rdy1, b_err} !== 2'b10 || b_rsp_data !== 16'h6666) begin errors++;
            $display("FAIL gap0_rsp got %b %h exp 10 6666", {b_rdy1, b_err}, b_rsp_data); end
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step();
            got = b_wrt;
        end
        checks++; if (!got || b_gnt1 !== 1'b1 || cyc != w + 2 + 3) begin errors++;
            $display("FAIL gap0_next got %0d cycles after done exp 3", cyc - w - 2); end
        req1 = 1'b0;
    endtask

    task automatic test_random();
        int          ptr, own, w, k, exp_r, last, nrdy, exp_gnt;
        logic [15:0] exp_cmd, rdv, exp_rsp;
        logic        exp_err, viol, cmd_bad, got;
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        ptr  = 0;
        req0 = 1'($urandom_range(0, 1));
        req1 = 1'($urandom_range(0, 1));
        if (!req0 && !req1) req0 = 1'b1;
        cmd0 = 16'($urandom); cmd1 = 16'($urandom);
        exp_gnt = cyc + 1;
        viol = 1'b0;
        for (int n = 0; n < 24; n++) begin
            got = 1'b0;
            for (int q = 0; q < 16 && !got; q++) begin
                step();
                if ((gnt0 & gnt1) || (wrt !== (gnt0 | gnt1))) viol = 1'b1;
                if (wrt) got = 1'b1;
                else if (rdy0 | rdy1) viol = 1'b1;
            end
            own = (req0 && req1) ? ptr : (req1 ? 1 : 0);
            checks++; if (!got || cyc != exp_gnt) begin errors++;
                $display("FAIL rnd_gnt_time txn %0d got %0d exp %0d", n, cyc, exp_gnt); end
            checks++; if ({gnt1, gnt0} !== ((own == 1) ? 2'b10 : 2'b01)) begin errors++;
                $display("FAIL rnd_owner txn %0d got %b exp owner %0d", n, {gnt1, gnt0}, own); end
            exp_cmd = (own == 1) ? cmd1 : cmd0;
            checks++; if (cmd !== exp_cmd) begin errors++;
                $display("FAIL rnd_cmd txn %0d got %h exp %h", n, cmd, exp_cmd); end
            w = cyc;
            if (own == 1) begin req1 = 1'b0; cmd1 = 16'($urandom); end
            else          begin req0 = 1'b0; cmd0 = 16'($urandom); end
            k       = $urandom_range(1, 20);
            rdv     = 16'($urandom);
            exp_r   = (k <= TO) ? w + k + 1 : w + TO + 1;
            exp_rsp = (k <= TO) ? rdv : 16'hFFFF;
            exp_err = (k > TO);
            last    = (w + k > exp_r) ? k : exp_r - w;
            nrdy    = 0;
            cmd_bad = 1'b0;
            for (int t = 1; t <= last + 1; t++) begin
                step();
                if (cmd !== exp_cmd) cmd_bad = 1'b1;
                if (gnt0 | gnt1 | wrt | (rdy0 & rdy1)) viol = 1'b1;
                if (rdy0 | rdy1) begin
                    nrdy++;
                    checks++; if (cyc != exp_r) begin errors++;
                        $display("FAIL rnd_rdy_time txn %0d got %0d exp %0d", n, cyc, exp_r); end
                    checks++; if ({rdy1, rdy0} !== ((own == 1) ? 2'b10 : 2'b01) ||
                                  rsp_data !== exp_rsp || err !== exp_err) begin errors++;
                        $display("FAIL rnd_rsp txn %0d got %b %h %b exp owner %0d %h %b",
                                 n, {rdy1, rdy0}, rsp_data, err, own, exp_rsp, exp_err); end
                end
                done    = (t == k);
                rd_data = (t == k) ? rdv : 16'($urandom);
            end
            checks++; if (nrdy != 1) begin errors++;
                $display("FAIL rnd_rdy_count txn %0d got %0d exp 1", n, nrdy); end
            checks++; if (cmd_bad || rsp_data !== exp_rsp) begin errors++;
                $display("FAIL rnd_hold txn %0d got cmd_bad %b rsp %h exp 0 %h", n, cmd_bad, rsp_data, exp_rsp); end
            ptr = 1 - own;
            if ($urandom_range(0, 1) == 1) begin
                if (own == 1) req1 = 1'b1; else req0 = 1'b1;
            end
            if (!req0 && !req1) begin
                if ($urandom_range(0, 1) == 1) req1 = 1'b1; else req0 = 1'b1;
            end
            exp_gnt = exp_r + 2 + GAP;
        end
        checks++; if (viol) begin errors++;
            $display("FAIL rnd_exclusive got violation exp none"); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; done = 1'b0;
        cmd0 = 16'h0; cmd1 = 16'h0; rd_data = 16'h0;
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_race();
        test_reset_wait();
        test_gap0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL provide parameters:
- GAP_CYC, default 4: idle cycles enforced between consecutive SPI transactions.
- TIMEOUT_CYC, default 2048: maximum WAIT cycles before a transaction is aborted; legal range 2..65535.
REQ-002 SHALL provide ports (clock and reset first):
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request level; held until gnt0.
- cmd0  in  16  requester 0 SPI command.
- req1  in  1  requester 1 request level; held until gnt1.
- cmd1  in  16  requester 1 SPI command.
- gnt0  out  1  one-cycle pulse: req0 accepted.
- gnt1  out  1  one-cycle pulse: req1 accepted.
- rdy0  out  1  one-cycle pulse: response for requester 0 on rsp_data.
- rdy1  out  1  one-cycle pulse: response for requester 1 on rsp_data.
- rsp_data  out  16  response word; held until next response.
- err  out  1  qualifies rdyN: 1 = timed-out transaction.
- busy  out  1  high in every state except IDLE.
- wrt  out  1  one-cycle start strobe to SPI master.
- cmd  out  16  command to SPI master.
- done  in  1  SPI master transaction-complete pulse.
- rd_data  in  16  SPI master read data, valid with done.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, GAP.
REQ-004 IDLE: if req0 or req1 high, SHALL select owner, latch the owner's cmdN into cmd, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-005 Selection SHALL be round-robin with a 1-bit priority pointer (reset 0 = requester 0 preferred).
- Only one requester high: that requester wins.
- Both high: the pointed-to requester wins.
REQ-006 ISSUE: SHALL assert wrt and the owner's gntN for exactly one cycle, clear the watchdog counter to 0, and go to WAIT.
REQ-007 cmd SHALL remain stable from ISSUE until the next IDLE->ISSUE latch; cmdN changes after latching SHALL have no effect.
REQ-008 WAIT: done SHALL capture rd_data into rsp_data, clear err, and go to RESP.
REQ-009 WAIT without done: the 16-bit watchdog SHALL increment each cycle. When it equals TIMEOUT_CYC-1, SHALL load rsp_data=16'hFFFF, set err=1, and go to RESP.
REQ-010 done and the timeout condition in the same cycle: done SHALL win (err=0).
REQ-011 done outside WAIT SHALL be ignored.
REQ-012 RESP: SHALL pulse the owner's rdyN for one cycle and set the pointer to the non-owner. Then go to GAP if GAP_CYC>0, else to IDLE.
REQ-013 GAP: SHALL remain exactly GAP_CYC cycles, then go to IDLE; requests SHALL be ignored during GAP.
REQ-014 Latency, with req sampled high in IDLE at cycle T and done at cycle D:
- wrt and gntN at T+1.
- rdyN at D+1.
- IDLE at D+2+GAP_CYC.
- Earliest next wrt at D+3+GAP_CYC.
REQ-015 A requester holding req high after its gnt SHALL be treated as a new request, subject to round-robin.
REQ-016 At most one of gnt0/gnt1 and at most one of rdy0/rdy1 SHALL be high in any cycle; wrt SHALL equal gnt0|gnt1.

Reset
REQ-017 rst high at a clock edge SHALL force:
- state to IDLE and pointer to 0.
- watchdog, cmd, rsp_data, err to 0.
- wrt, gnt0, gnt1, rdy0, rdy1, busy to 0.
REQ-018 rst asserted mid-transaction SHALL abandon it silently: no rdyN and no err. A done arriving after reset release SHALL be ignored.

Verification
REQ-019 Single request: req0=1, cmd0=16'hA55A, done with rd_data=16'h1234 8 cycles after wrt -> gnt0 and wrt with cmd=A55A one cycle after req; rdy0, rsp_data=1234, err=0 one cycle after done.
REQ-020 Contention: req0=req1=1 continuously from reset -> grant order 0,1,0,1. Consecutive wrt pulses SHALL be separated by at least GAP_CYC+2 cycles after each done.
REQ-021 Timeout: TIMEOUT_CYC=16, no done -> rdyN with rsp_data=FFFF and err=1 exactly 17 cycles after wrt; the next request is then served normally.
REQ-022 Race: done in the same cycle the watchdog reaches TIMEOUT_CYC-1 -> rsp_data=rd_data, err=0.
REQ-023 Reset in WAIT: rst pulse 3 cycles after wrt, then done -> no rdy0/rdy1; all outputs 0; pointer=0.
REQ-024 GAP_CYC=0: back-to-back req1 -> next wrt exactly 3 cycles after done.
